multi_dose_reminder: RTL and testbench

MULTI_DOSE_REMINDER -- requirements
Module: multi_dose_reminder

---
 rtl/multi_dose_reminder.sv | 159 +++++++++++++++
 tb/tb_multi_dose_reminder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_dose_reminder.sv
// Multi-channel medication reminder: per-channel countdown timers that raise a
// "dose due" alert on expiry, count missed doses, and report the soonest channel.
module multi_dose_reminder #(
    parameter int NUM_CH     = 4,
    parameter int INTERVAL_W = 17,
    parameter int MISS_W     = 4,
    parameter int DEMO_STEP  = 60,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tick,
    input  logic                     demo_mode,
    input  logic                     load,
    input  logic [CH_W-1:0]          load_ch,
    input  logic [INTERVAL_W-1:0]    load_interval,
    input  logic                     start,
    input  logic                     pause,
    input  logic                     ack,
    input  logic [CH_W-1:0]          ack_ch,
    output logic [NUM_CH-1:0]        alert,
    output logic                     alert_any,
    output logic [CH_W-1:0]          next_ch,
    output logic [INTERVAL_W-1:0]    next_remaining,
    output logic [NUM_CH*MISS_W-1:0] miss_count,
    output logic [1:0]               state
);

    // Control inputs (tick, load, start, pause, ack) are single-cycle pulses
    // sampled on the rising edge; there is no back-pressure on any of them.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_PAUSED = 2'b10
    } state_e;

    state_e state_q, state_d;

    logic [NUM_CH-1:0][INTERVAL_W-1:0] interval_q, interval_d;
    logic [NUM_CH-1:0][INTERVAL_W-1:0] remaining_q, remaining_d;
    logic [NUM_CH-1:0][MISS_W-1:0]     miss_q, miss_d;
    logic [NUM_CH-1:0]                 alert_q, alert_d;
    logic [CH_W-1:0]                   next_ch_q, next_ch_d;
    logic [INTERVAL_W-1:0]             next_rem_q, next_rem_d;

    logic [INTERVAL_W-1:0]             step;
    logic                              tick_run;
    logic                              load_ok;
    logic [NUM_CH-1:0]                 enabled;
    logic [NUM_CH-1:0]                 expire;
    logic [NUM_CH-1:0]                 ack_hit;
    logic [NUM_CH-1:0]                 load_hit;
    logic [NUM_CH-1:0][INTERVAL_W-1:0] sub_rem;
    logic                              found;

    // Mode FSM; simultaneous start and pause is treated as no request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start && !pause) state_d = ST_RUN;
            ST_RUN:    if (pause && !start) state_d = ST_PAUSED;
            ST_PAUSED: if (start && !pause) state_d = ST_RUN;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign step     = demo_mode ? INTERVAL_W'(DEMO_STEP) : INTERVAL_W'(1);
    assign tick_run = tick && (state_q == ST_RUN);
    assign load_ok  = load && (state_q == ST_IDLE || state_q == ST_PAUSED)
                      && (int'(load_ch) < NUM_CH);

    always_comb begin
        enabled  = '0;
        expire   = '0;
        ack_hit  = '0;
        load_hit = '0;
        sub_rem  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            enabled[i]  = (interval_q[i] != '0);
            sub_rem[i]  = (remaining_q[i] > step) ? remaining_q[i] - step : '0;
            expire[i]   = tick_run && enabled[i] && (sub_rem[i] == '0);
            ack_hit[i]  = ack && (ack_ch == CH_W'(i)) && alert_q[i];
            load_hit[i] = load_ok && (load_ch == CH_W'(i));
        end
    end

    // An expiry that coincides with an ack keeps the alert up but does not
    // count as a miss: the dose being acknowledged is the one that was due.
    always_comb begin
        interval_d  = interval_q;
        remaining_d = remaining_q;
        miss_d      = miss_q;
        alert_d     = alert_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (load_hit[i]) begin
                interval_d[i]  = load_interval;
                remaining_d[i] = load_interval;
                alert_d[i]     = 1'b0;
                miss_d[i]      = '0;
            end else if (expire[i]) begin
                remaining_d[i] = interval_q[i];
                alert_d[i]     = 1'b1;
                if (alert_q[i] && !ack_hit[i] && (miss_q[i] != {MISS_W{1'b1}})) begin
                    miss_d[i] = miss_q[i] + MISS_W'(1);
                end
            end else begin
                if (tick_run && enabled[i]) begin
                    remaining_d[i] = sub_rem[i];
                end
                if (ack_hit[i]) begin
                    alert_d[i] = 1'b0;
                end
            end
        end
    end

    // Soonest-due search over the registered remaining values; strict '<'
    // keeps the lowest index on ties.
    always_comb begin
        next_ch_d  = '0;
        next_rem_d = '1;
        found      = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (enabled[i] && (!found || remaining_q[i] < next_rem_d)) begin
                next_ch_d  = CH_W'(i);
                next_rem_d = remaining_q[i];
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            interval_q  <= '0;
            remaining_q <= '0;
            miss_q      <= '0;
            alert_q     <= '0;
            next_ch_q   <= '0;
            next_rem_q  <= '1;
        end else begin
            state_q     <= state_d;
            interval_q  <= interval_d;
            remaining_q <= remaining_d;
            miss_q      <= miss_d;
            alert_q     <= alert_d;
            next_ch_q   <= next_ch_d;
            next_rem_q  <= next_rem_d;
        end
    end

    assign alert          = alert_q;
    assign alert_any      = |alert_q;
    assign next_ch        = next_ch_q;
    assign next_remaining = next_rem_q;
    assign miss_count     = miss_q;
    assign state          = state_q;

endmodule

// File: tb/tb_multi_dose_reminder.sv
// Directed bench for multi_dose_reminder with default parameters
// (4 channels, 17-bit intervals, 4-bit miss counters, 60 s demo step).
module tb_multi_dose_reminder;

    localparam int NUM_CH     = 4;
    localparam int INTERVAL_W = 17;
    localparam int MISS_W     = 4;
    localparam int CH_W       = 2;
    localparam logic [INTERVAL_W-1:0] ALL_ONES = 17'h1FFFF;

    logic                     clk;
    logic                     reset;
    logic                     tick;
    logic                     demo_mode;
    logic                     load;
    logic [CH_W-1:0]          load_ch;
    logic [INTERVAL_W-1:0]    load_interval;
    logic                     start;
    logic                     pause;
    logic                     ack;
    logic [CH_W-1:0]          ack_ch;
    logic [NUM_CH-1:0]        alert;
    logic                     alert_any;
    logic [CH_W-1:0]          next_ch;
    logic [INTERVAL_W-1:0]    next_remaining;
    logic [NUM_CH*MISS_W-1:0] miss_count;
    logic [1:0]               state;

    int errors = 0;
    int checks = 0;

    multi_dose_reminder #(
        .NUM_CH(NUM_CH), .INTERVAL_W(INTERVAL_W), .MISS_W(MISS_W), .DEMO_STEP(60)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .demo_mode(demo_mode),
        .load(load), .load_ch(load_ch), .load_interval(load_interval),
        .start(start), .pause(pause), .ack(ack), .ack_ch(ack_ch),
        .alert(alert), .alert_any(alert_any), .next_ch(next_ch),
        .next_remaining(next_remaining), .miss_count(miss_count), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic cyc(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; tick = 1'b0; demo_mode = 1'b0; load = 1'b0; load_ch = '0;
        load_interval = '0; start = 1'b0; pause = 1'b0; ack = 1'b0; ack_ch = '0;
        cyc(2);
        reset = 1'b0;
        cyc(1);
    endtask

    task automatic load_chan(input logic [CH_W-1:0] ch, input logic [INTERVAL_W-1:0] val);
        load = 1'b1; load_ch = ch; load_interval = val;
        cyc(1);
        load = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(1); start = 1'b0;
    endtask

    task automatic pulse_pause();
        pause = 1'b1; cyc(1); pause = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            tick = 1'b1; cyc(1); tick = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        if (state !== 2'b00) begin errors++; $display("FAIL reset_state: got %b expected 00", state); end
        checks++;
        if (alert !== 4'b0000 || alert_any !== 1'b0) begin errors++; $display("FAIL reset_alert: got %b/%b expected 0000/0", alert, alert_any); end
        checks++;
        if (miss_count !== 16'h0000) begin errors++; $display("FAIL reset_miss: got %h expected 0000", miss_count); end
        checks++;
        if (next_ch !== 2'd0 || next_remaining !== ALL_ONES) begin errors++; $display("FAIL reset_next: got %0d/%h expected 0/1ffff", next_ch, next_remaining); end
        checks++;
    endtask

    task automatic test_countdown();
        do_reset();
        load_chan(2'd0, 17'd5);
        load_chan(2'd2, 17'd3);
        cyc(1);
        if (next_ch !== 2'd2 || next_remaining !== 17'd3) begin errors++; $display("FAIL cd_next_loaded: got %0d/%0d expected 2/3", next_ch, next_remaining); end
        checks++;
        pulse_start();
        if (state !== 2'b01) begin errors++; $display("FAIL cd_state_run: got %b expected 01", state); end
        checks++;
        ticks(3);
        if (alert !== 4'b0100 || alert_any !== 1'b1) begin errors++; $display("FAIL cd_alert: got %b/%b expected 0100/1", alert, alert_any); end
        checks++;
        if (next_ch !== 2'd2 || next_remaining !== 17'd1) begin errors++; $display("FAIL cd_next_latency: got %0d/%0d expected 2/1", next_ch, next_remaining); end
        checks++;
        cyc(1);
        if (next_ch !== 2'd0 || next_remaining !== 17'd2) begin errors++; $display("FAIL cd_next_after: got %0d/%0d expected 0/2", next_ch, next_remaining); end
        checks++;
    endtask

    task automatic test_demo_miss();
        do_reset();
        load_chan(2'd1, 17'd120);
        demo_mode = 1'b1;
        pulse_start();
        ticks(2);
        if (alert !== 4'b0010) begin errors++; $display("FAIL demo_alert: got %b expected 0010", alert); end
        checks++;
        if (next_ch !== 2'd1 || next_remaining !== 17'd60) begin errors++; $display("FAIL demo_next_mid: got %0d/%0d expected 1/60", next_ch, next_remaining); end
        checks++;
        cyc(1);
        if (next_remaining !== 17'd120) begin errors++; $display("FAIL demo_reload: got %0d expected 120", next_remaining); end
        checks++;
        ticks(2);
        if (miss_count !== 16'h0010) begin errors++; $display("FAIL demo_miss: got %h expected 0010", miss_count); end
        checks++;
        if (alert !== 4'b0010) begin errors++; $display("FAIL demo_alert_held: got %b expected 0010", alert); end
        checks++;
        ack = 1'b1; ack_ch = 2'd1; cyc(1); ack = 1'b0;
        if (alert !== 4'b0000 || alert_any !== 1'b0) begin errors++; $display("FAIL demo_ack: got %b/%b expected 0000/0", alert, alert_any); end
        checks++;
        demo_mode = 1'b0;
    endtask

    task automatic test_ack_expiry();
        do_reset();
        load_chan(2'd0, 17'd1);
        pulse_start();
        tick = 1'b1; ack = 1'b1; ack_ch = 2'd0; cyc(1);
        if (alert !== 4'b0001 || miss_count !== 16'h0000) begin errors++; $display("FAIL ae_first: got %b/%h expected 0001/0000", alert, miss_count); end
        checks++;
        cyc(1);
        if (alert !== 4'b0001 || miss_count !== 16'h0000) begin errors++; $display("FAIL ae_same_cycle: got %b/%h expected 0001/0000", alert, miss_count); end
        checks++;
        ack = 1'b0; cyc(1); tick = 1'b0;
        if (miss_count !== 16'h0001) begin errors++; $display("FAIL ae_miss: got %h expected 0001", miss_count); end
        checks++;
        ack = 1'b1; ack_ch = 2'd2; cyc(1);
        if (alert !== 4'b0001) begin errors++; $display("FAIL ae_ack_wrong_ch: got %b expected 0001", alert); end
        checks++;
        ack_ch = 2'd0; cyc(1); ack = 1'b0;
        if (alert !== 4'b0000) begin errors++; $display("FAIL ae_ack: got %b expected 0000", alert); end
        checks++;
    endtask

    task automatic test_pause_load();
        do_reset();
        load_chan(2'd0, 17'd10);
        pulse_start();
        ticks(1);
        cyc(1);
        if (next_remaining !== 17'd9) begin errors++; $display("FAIL pl_run_tick: got %0d expected 9", next_remaining); end
        checks++;
        pulse_pause();
        if (state !== 2'b10) begin errors++; $display("FAIL pl_state_paused: got %b expected 10", state); end
        checks++;
        ticks(10);
        cyc(1);
        if (next_remaining !== 17'd9 || state !== 2'b10) begin errors++; $display("FAIL pl_frozen: got %0d/%b expected 9/10", next_remaining, state); end
        checks++;
        pulse_start();
        load_chan(2'd0, 17'd50);
        cyc(2);
        if (next_remaining !== 17'd9) begin errors++; $display("FAIL pl_load_in_run: got %0d expected 9", next_remaining); end
        checks++;
        start = 1'b1; pause = 1'b1; cyc(1); start = 1'b0; pause = 1'b0;
        if (state !== 2'b01) begin errors++; $display("FAIL pl_both_run: got %b expected 01", state); end
        checks++;
        pulse_pause();
        start = 1'b1; pause = 1'b1; cyc(1); start = 1'b0; pause = 1'b0;
        if (state !== 2'b10) begin errors++; $display("FAIL pl_both_paused: got %b expected 10", state); end
        checks++;
        load_chan(2'd1, 17'd4);
        cyc(2);
        if (next_ch !== 2'd1 || next_remaining !== 17'd4) begin errors++; $display("FAIL pl_load_paused: got %0d/%0d expected 1/4", next_ch, next_remaining); end
        checks++;
    endtask

    task automatic test_saturate_async_reset();
        do_reset();
        load_chan(2'd0, 17'd1);
        pulse_start();
        ticks(17);
        if (miss_count !== 16'h000F || alert !== 4'b0001) begin errors++; $display("FAIL sat_miss: got %h/%b expected 000f/0001", miss_count, alert); end
        checks++;
        if (next_remaining !== 17'd1) begin errors++; $display("FAIL sat_next: got %0d expected 1", next_remaining); end
        checks++;
        reset = 1'b1;
        #1;
        if (state !== 2'b00 || alert !== 4'b0000 || alert_any !== 1'b0) begin errors++; $display("FAIL async_state_alert: got %b/%b/%b expected 00/0000/0", state, alert, alert_any); end
        checks++;
        if (miss_count !== 16'h0000 || next_ch !== 2'd0 || next_remaining !== ALL_ONES) begin errors++; $display("FAIL async_counts: got %h/%0d/%h expected 0000/0/1ffff", miss_count, next_ch, next_remaining); end
        checks++;
        cyc(1);
        reset = 1'b0;
        cyc(1);
        load_chan(2'd0, 17'd1);
        ticks(3);
        cyc(1);
        if (alert !== 4'b0000 || state !== 2'b00 || next_remaining !== 17'd1) begin errors++; $display("FAIL post_reset_idle: got %b/%b/%0d expected 0000/00/1", alert, state, next_remaining); end
        checks++;
    endtask

    task automatic test_disabled();
        do_reset();
        cyc(2);
        if (next_ch !== 2'd0 || next_remaining !== ALL_ONES) begin errors++; $display("FAIL dis_none: got %0d/%h expected 0/1ffff", next_ch, next_remaining); end
        checks++;
        load_chan(2'd3, 17'd0);
        load_chan(2'd2, 17'd7);
        cyc(1);
        if (next_ch !== 2'd2 || next_remaining !== 17'd7) begin errors++; $display("FAIL dis_ch2: got %0d/%0d expected 2/7", next_ch, next_remaining); end
        checks++;
        load_chan(2'd2, 17'd0);
        pulse_start();
        ticks(8);
        cyc(1);
        if (alert !== 4'b0000 || next_ch !== 2'd0 || next_remaining !== ALL_ONES) begin errors++; $display("FAIL dis_never: got %b/%0d/%h expected 0000/0/1ffff", alert, next_ch, next_remaining); end
        checks++;
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; demo_mode = 1'b0; load = 1'b0; load_ch = '0;
        load_interval = '0; start = 1'b0; pause = 1'b0; ack = 1'b0; ack_ch = '0;
        test_reset();
        test_countdown();
        test_demo_miss();
        test_ack_expiry();
        test_pause_load();
        test_saturate_async_reset();
        test_disabled();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
